clock_rate_ctrl: RTL and testbench

Sequencing controller for the digital clock's time base: synchronizes and debounces the three speed switches, resolves them by priority into a tick rate (1/10/100/1000 Hz), and drives a single divider counter. Rate changes are deferred to a period boundary, so no tick period is ever truncated or stretched. It sits between the board switches and the seconds/minutes counters, which consume `tick` as a clock enable.

---
 rtl/clock_rate_ctrl.sv | 168 ++++++++++++++++
 tb/tb_clock_rate_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_rate_ctrl.sv
// clock_rate_ctrl: switch-selected 1/10/100/1000 Hz time base; rate changes land on a period boundary.
// Optional switch debounce stage is built when CLOCK_RATE_CTRL_DEBOUNCE_EN is defined.
module clock_rate_ctrl #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       switch_x10,
  input  logic       switch_x100,
  input  logic       switch_x1000,
  output logic       tick,
  output logic       clk_hz,
  output logic [1:0] rate_sel,
  output logic       rate_change
);

  localparam logic [26:0] L0 = 27'(CLK_HZ - 1);
  localparam logic [26:0] L1 = 27'(CLK_HZ / 10 - 1);
  localparam logic [26:0] L2 = 27'(CLK_HZ / 100 - 1);
  localparam logic [26:0] L3 = 27'(CLK_HZ / 1000 - 1);
  localparam logic [26:0] M0 = 27'(CLK_HZ / 2 - 1);
  localparam logic [26:0] M1 = 27'(CLK_HZ / 20 - 1);
  localparam logic [26:0] M2 = 27'(CLK_HZ / 200 - 1);
  localparam logic [26:0] M3 = 27'(CLK_HZ / 2000 - 1);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_t;

  logic [2:0]  r_s1;
  logic [2:0]  r_s2;
  logic [2:0]  w_acc;
  logic [1:0]  w_req;
  logic [26:0] r_cnt;
  logic [26:0] w_last;
  logic [26:0] w_mid;
  logic        w_wrap;
  logic        w_apply;
  state_t      r_state;
  state_t      w_nstate;
  logic [1:0]  r_rate;
  logic [1:0]  r_pend;
  logic [1:0]  w_npend;
  logic        r_tick;
  logic        r_clk;
  logic        r_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= {switch_x1000, switch_x100, switch_x10};
      r_s2 <= r_s1;
    end
  end

`ifdef CLOCK_RATE_CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [2:0]    r_cand;
  logic [2:0]    r_acc;
  logic [DW-1:0] r_db;

  // Counter saturates once the candidate is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cand <= '0;
      r_acc  <= '0;
      r_db   <= '0;
    end else if (r_s2 != r_cand) begin
      r_cand <= r_s2;
      r_db   <= '0;
    end else if (r_db == DB_LAST) begin
      r_acc  <= r_cand;
    end else begin
      r_db   <= r_db + 1'b1;
    end
  end

  assign w_acc = r_acc;
`else
  wire w_unused_db = (DEBOUNCE_CYCLES > 0);

  assign w_acc = r_s2;
`endif

  always_comb begin
    w_req = 2'd0;
    unique case (1'b1)
      w_acc[2]:             w_req = 2'd3;
      w_acc[2:1] == 2'b01:  w_req = 2'd2;
      w_acc == 3'b001:      w_req = 2'd1;
      default:              w_req = 2'd0;
    endcase
  end

  always_comb begin
    w_last = L0;
    w_mid  = M0;
    unique case (r_rate)
      2'd0: begin w_last = L0; w_mid = M0; end
      2'd1: begin w_last = L1; w_mid = M1; end
      2'd2: begin w_last = L2; w_mid = M2; end
      2'd3: begin w_last = L3; w_mid = M3; end
      default: ;
    endcase
  end

  assign w_wrap = (r_cnt == w_last);

  always_comb begin
    w_nstate = r_state;
    w_npend  = r_pend;
    w_apply  = 1'b0;
    unique case (r_state)
      ST_STABLE: begin
        if (w_req != r_rate) begin
          w_nstate = ST_PENDING;
          w_npend  = w_req;
        end
      end
      ST_PENDING: begin
        if (w_req == r_rate) begin
          w_nstate = ST_STABLE;
        end else if (w_wrap) begin
          w_nstate = ST_STABLE;
          w_apply  = 1'b1;
        end else begin
          w_npend  = w_req;
        end
      end
      default: w_nstate = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_STABLE;
      r_pend  <= 2'd0;
      r_rate  <= 2'd0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_clk   <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pend  <= w_npend;
      r_cnt   <= w_wrap ? 27'd0 : r_cnt + 27'd1;
      r_tick  <= w_wrap;
      r_chg   <= w_apply;
      if (w_apply) r_rate <= r_pend;
      if (w_wrap)
        r_clk <= 1'b0;
      else if (r_cnt == w_mid)
        r_clk <= 1'b1;
    end
  end

  assign tick        = r_tick;
  assign clk_hz      = r_clk;
  assign rate_sel    = r_rate;
  assign rate_change = r_chg;

endmodule

// File: tb/tb_clock_rate_ctrl.sv
// tb_clock_rate_ctrl: directed scenarios plus random switch traffic,
// checked every cycle against a cycle-position reference model.
module tb_clock_rate_ctrl;

  localparam int CLK_HZ = 2000;
  localparam int DEB    = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sw = 3'b000;
  logic       tick;
  logic       clk_hz;
  logic [1:0] rate_sel;
  logic       rate_change;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  clock_rate_ctrl #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .switch_x10(sw[0]),
    .switch_x100(sw[1]),
    .switch_x1000(sw[2]),
    .tick(tick),
    .clk_hz(clk_hz),
    .rate_sel(rate_sel),
    .rate_change(rate_change)
  );

  always #5 clk = ~clk;

  function automatic int per(input int r);
    case (r)
      0: return CLK_HZ;
      1: return CLK_HZ / 10;
      2: return CLK_HZ / 100;
      default: return CLK_HZ / 1000;
    endcase
  endfunction

  function automatic int enc(input logic [2:0] v);
    if (v[2]) return 3;
    if (v[1]) return 2;
    if (v[0]) return 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors < 30)
        $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: position within the period, active rate, and the
  // request seen now and one cycle ago. A change applies at a wrap only
  // if the request differed from the rate in both of those cycles.
  int         m_ph;
  int         m_rate;
  int         m_req;
  int         m_req_prev;
  logic [2:0] m_s1;
  logic [2:0] m_acc;
  logic [2:0] m_s2q[$];
  int         e_tick;
  int         e_clk;
  int         e_rc;

  task automatic m_reset();
    m_ph = 0; m_rate = 0; m_req = 0; m_req_prev = 0;
    m_s1 = '0; m_acc = '0;
    m_s2q.delete();
    for (int i = 0; i <= DEB; i++) m_s2q.push_back(3'b000);
    e_tick = 0; e_clk = 0; e_rc = 0;
    cyc = 0;
  endtask

  task automatic m_step();
    bit wrap;
    bit apply;
    bit same;
    logic [2:0] s2n;
    wrap  = (m_ph == per(m_rate) - 1);
    apply = wrap && (m_req_prev != m_rate) && (m_req != m_rate);
    e_tick = int'(wrap);
    e_rc   = int'(apply);
    if (apply) m_rate = m_req_prev;
    m_ph  = wrap ? 0 : m_ph + 1;
    e_clk = int'(m_ph >= per(m_rate) / 2);
    s2n  = m_s1;
    same = 1'b1;
    foreach (m_s2q[i]) if (m_s2q[i] != m_s2q[0]) same = 1'b0;
    if (same) m_acc = m_s2q[0];
    m_s2q.push_back(s2n);
    void'(m_s2q.pop_front());
    m_s1 = sw;
    m_req_prev = m_req;
`ifdef CLOCK_RATE_CTRL_DEBOUNCE_EN
    m_req = enc(m_acc);
`else
    m_req = enc(s2n);
`endif
    cyc++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("tick", int'(tick), e_tick);
      chk("clk_hz", int'(clk_hz), e_clk);
      chk("rate_sel", int'(rate_sel), m_rate);
      chk("rate_change", int'(rate_change), e_rc);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic at(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  initial begin
    // Reset, no switches
    sw = 3'b000;
    do_reset();
    at(999);  chk("s1_clk_999", int'(clk_hz), 0);
    at(1000); chk("s1_clk_1000", int'(clk_hz), 1);
    at(1999); chk("s1_tick_1999", int'(tick), 0);
    at(2000); chk("s1_tick_2000", int'(tick), 1);
    chk("s1_clk_2000", int'(clk_hz), 0);
    at(3000); chk("s1_clk_3000", int'(clk_hz), 1);
    at(4000); chk("s1_tick_4000", int'(tick), 1);
    at(6000); chk("s1_tick_6000", int'(tick), 1);
    chk("s1_rate", int'(rate_sel), 0);

    // x10 mid-period, then priority x10+x1000
    do_reset();
    at(500);  sw = 3'b001;
    at(1999); chk("s2_rate_1999", int'(rate_sel), 0);
    at(2000); chk("s2_rate_2000", int'(rate_sel), 1);
    chk("s2_chg_2000", int'(rate_change), 1);
    chk("s2_tick_2000", int'(tick), 1);
    at(2199); chk("s2_tick_2199", int'(tick), 0);
    at(2200); chk("s2_tick_2200", int'(tick), 1);
    chk("s2_chg_2200", int'(rate_change), 0);
    at(2400); chk("s2_tick_2400", int'(tick), 1);
    sw = 3'b101;
    at(2600); chk("s3_rate_2600", int'(rate_sel), 3);
    chk("s3_chg_2600", int'(rate_change), 1);
    at(2700); chk("s3_tick_2700", int'(tick), 1);
    chk("s3_clk_2700", int'(clk_hz), 0);
    at(2701); chk("s3_tick_2701", int'(tick), 0);
    chk("s3_clk_2701", int'(clk_hz), 1);

    // Cancel, glitch reject, steady accept, reset mid-period
    sw = 3'b000;
    do_reset();
    at(100);  sw = 3'b001;
    at(1000); sw = 3'b000;
    at(2000); chk("s5_tick_2000", int'(tick), 1);
    chk("s5_chg_2000", int'(rate_change), 0);
    at(2200); chk("s5_tick_2200", int'(tick), 0);
    at(4000); chk("s5_tick_4000", int'(tick), 1);
    chk("s5_rate_4000", int'(rate_sel), 0);
    at(4100); sw = 3'b010;
    at(4103); sw = 3'b000;
    at(6000); chk("s4_rate_6000", int'(rate_sel), 0);
    chk("s4_chg_6000", int'(rate_change), 0);
    at(6100); sw = 3'b010;
    at(8000); chk("s4_rate_8000", int'(rate_sel), 2);
    chk("s4_chg_8000", int'(rate_change), 1);
    at(8005); sw = 3'b001;
    at(8015); chk("s6_clk_8015", int'(clk_hz), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("s6_rst_tick", int'(tick), 0);
    chk("s6_rst_clk", int'(clk_hz), 0);
    chk("s6_rst_rate", int'(rate_sel), 0);
    chk("s6_rst_chg", int'(rate_change), 0);
    sw = 3'b000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    at(1999); chk("s6_tick_1999", int'(tick), 0);
    at(2000); chk("s6_tick_2000", int'(tick), 1);
    chk("s6_rate_2000", int'(rate_sel), 0);

    // Random switch traffic, glitches and one asynchronous reset
    do_reset();
    for (int s = 0; s < 70; s++) begin
      int hold;
      sw = 3'($urandom);
      if ($urandom_range(0, 3) == 0)
        hold = $urandom_range(1, 8);
      else
        hold = $urandom_range(20, 400);
      repeat (hold) @(negedge clk);
      if (s == 35) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    sw = 3'b000;
    repeat (2100) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
